// File: rtl/adder_share_arb.sv
// Round-robin arbiter plus one-entry registered result slot sharing one W-bit adder among NREQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module adder_share_arb #(
   parameter int NREQ = 3,
   parameter int W    = 32,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [W-1:0]      resp_y,
   output logic              resp_cout,
   output logic [IDW-1:0]    resp_id
);

   typedef enum logic {EMPTY, FULL} slot_t;

   slot_t          state, state_nxt;
   logic           can_issue;
   logic           found;
   logic           fire;
   logic [IDW-1:0] winner;
   logic [W-1:0]   a_sel, b_sel;
   logic [W:0]     sum;

   assign resp_valid = (state == FULL);
   assign can_issue  = !resp_valid || resp_ready;
   assign fire       = found && can_issue;

`ifdef ADDER_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found  = 1'b1;
            winner = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] rr_sel;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      found  = 1'b0;
      winner = '0;
      rr_sel = '0;
      for (int k = 1; k <= NREQ; k++) begin
         rr_sel = IDW'((int'(last_grant) + k) % NREQ);
         if (!found && req_valid[rr_sel]) begin
            found  = 1'b1;
            winner = rr_sel;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     last_grant <= IDW'(NREQ - 1);
      else if (fire) last_grant <= winner;
   end
`endif

   always_comb begin
      req_ready = '0;
      a_sel     = '0;
      b_sel     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            req_ready[i] = fire;
            a_sel        = req_a[i*W +: W];
            b_sel        = req_b[i*W +: W];
         end
      end
   end

   assign sum = {1'b0, a_sel} + {1'b0, b_sel};

   // A fresh issue wins over a drain, keeping the slot full for back-to-back results.
   always_comb begin
      state_nxt = state;
      if (fire)            state_nxt = FULL;
      else if (resp_ready) state_nxt = EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_y    <= '0;
         resp_cout <= 1'b0;
         resp_id   <= '0;
      end else if (fire) begin
         resp_y    <= sum[W-1:0];
         resp_cout <= sum[W];
         resp_id   <= winner;
      end
   end

endmodule
